// File: rtl/axi4full_sram_burst.sv
// AXI4-full slave over a byte-maskable register-array SRAM with FIXED/INCR/WRAP bursts on independent read and write channels.
// Read data is valid 1 cycle after ar_fire and is held while i_rready is low; ready outputs come from FSM state only.
module axi4full_sram_burst #(
  parameter int                  DATA_WIDTH = 64,
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  STRB_WIDTH = DATA_WIDTH / 8,
  parameter int                  ID_WIDTH   = 4,
  parameter int                  DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic                  i_aclk,
  input  logic                  i_arsetn,
  input  logic [ID_WIDTH-1:0]   i_awid,
  input  logic [ADDR_WIDTH-1:0] i_awaddr,
  input  logic [7:0]            i_awlen,
  input  logic [2:0]            i_awsize,
  input  logic [1:0]            i_awburst,
  input  logic                  i_awvalid,
  output logic                  o_awready,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [STRB_WIDTH-1:0] i_wstrb,
  input  logic                  i_wlast,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  output logic [ID_WIDTH-1:0]   o_bid,
  output logic [1:0]            o_bresp,
  output logic                  o_bvalid,
  input  logic                  i_bready,
  input  logic [ID_WIDTH-1:0]   i_arid,
  input  logic [ADDR_WIDTH-1:0] i_araddr,
  input  logic [7:0]            i_arlen,
  input  logic [2:0]            i_arsize,
  input  logic [1:0]            i_arburst,
  input  logic                  i_arvalid,
  output logic                  o_arready,
  output logic [ID_WIDTH-1:0]   o_rid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [1:0]            o_rresp,
  output logic                  o_rlast,
  output logic                  o_rvalid,
  input  logic                  i_rready
);

  localparam int OFFS  = $clog2(STRB_WIDTH);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(DEPTH * STRB_WIDTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [7:0] len,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] sz, inc, span, lb, res;
    sz   = ADDR_WIDTH'(1) << size;
    inc  = (a & ~(sz - ADDR_WIDTH'(1))) + sz;
    span = sz * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1));
    lb   = a & ~(span - ADDR_WIDTH'(1));
    if (burst == BURST_FIXED)     res = a;
    else if (burst == BURST_WRAP) res = (inc == lb + span) ? lb : inc;
    else                          res = inc;
    return res;
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return {1'b0, off} < MEM_BYTES;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return off[OFFS +: IDX_W];
  endfunction

  // Whole-burst errors: oversized beat, reserved burst type, or WRAP with a non power-of-2 length.
  function automatic logic burst_bad(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (int'(size) > OFFS) || (burst == 2'b11) || ((burst == BURST_WRAP) && !wrap_len_ok);
  endfunction

  // ---------------- read channel ----------------
  r_state_t              r_state, r_state_d;
  logic [ADDR_WIDTH-1:0] r_addr, r_nxt, ld_addr;
  logic [7:0]            r_len, r_beat;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_bad, ar_bad, ld_bad, ld_ok, ar_fire, r_fire;

  assign ar_fire = i_arvalid && o_arready;
  assign r_fire  = o_rvalid && i_rready;
  assign ar_bad  = burst_bad(i_arlen, i_arsize, i_arburst);
  assign r_nxt   = next_addr(r_addr, r_len, r_size, r_burst);
  assign ld_addr = ar_fire ? i_araddr : r_nxt;
  assign ld_bad  = ar_fire ? ar_bad : r_bad;
  assign ld_ok   = !ld_bad && in_range(ld_addr);

  always_ff @(posedge i_aclk or negedge i_arsetn) begin
    if (!i_arsetn) r_state <= R_IDLE;
    else           r_state <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state;
    case (r_state)
      R_IDLE:  if (i_arvalid) r_state_d = R_DATA;
      R_DATA:  if (i_rready && o_rlast) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    o_arready = (r_state == R_IDLE);
    o_rvalid  = (r_state == R_DATA);
    o_rlast   = (r_state == R_DATA) && (r_beat == r_len);
  end

  // Next beat is fetched on the accepting edge so a stalled beat never changes under the master.
  always_ff @(posedge i_aclk or negedge i_arsetn) begin
    if (!i_arsetn) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_beat  <= '0;
      r_bad   <= 1'b0;
      o_rid   <= '0;
      o_rdata <= '0;
      o_rresp <= RESP_OKAY;
    end else if (ar_fire || (r_fire && !o_rlast)) begin
      if (ar_fire) begin
        o_rid   <= i_arid;
        r_addr  <= i_araddr;
        r_len   <= i_arlen;
        r_size  <= i_arsize;
        r_burst <= i_arburst;
        r_bad   <= ar_bad;
        r_beat  <= '0;
      end else begin
        r_addr <= r_nxt;
        r_beat <= r_beat + 8'd1;
      end
      o_rdata <= ld_ok ? mem[word_idx(ld_addr)] : '0;
      o_rresp <= ld_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // ---------------- write channel ----------------
  w_state_t              w_state, w_state_d;
  logic [ADDR_WIDTH-1:0] w_addr, w_nxt;
  logic [7:0]            w_len, w_beat;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_bad, w_err, w_ok, w_last_beat, aw_fire, w_fire;
  logic [IDX_W-1:0]      w_idx;

  assign aw_fire     = i_awvalid && o_awready;
  assign w_fire      = i_wvalid && o_wready;
  assign w_nxt       = next_addr(w_addr, w_len, w_size, w_burst);
  assign w_ok        = !w_bad && in_range(w_addr);
  assign w_idx       = word_idx(w_addr);
  assign w_last_beat = (w_beat == w_len);

  always_ff @(posedge i_aclk or negedge i_arsetn) begin
    if (!i_arsetn) w_state <= W_IDLE;
    else           w_state <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state;
    case (w_state)
      W_IDLE:  if (i_awvalid) w_state_d = W_DATA;
      W_DATA:  if (i_wvalid && w_last_beat) w_state_d = W_RESP;
      W_RESP:  if (i_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    o_awready = (w_state == W_IDLE);
    o_wready  = (w_state == W_DATA);
    o_bvalid  = (w_state == W_RESP);
    o_bresp   = (w_state == W_RESP && w_err) ? RESP_SLVERR : RESP_OKAY;
  end

  always_ff @(posedge i_aclk or negedge i_arsetn) begin
    if (!i_arsetn) begin
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_beat  <= '0;
      w_bad   <= 1'b0;
      w_err   <= 1'b0;
      o_bid   <= '0;
    end else if (aw_fire) begin
      o_bid   <= i_awid;
      w_addr  <= i_awaddr;
      w_len   <= i_awlen;
      w_size  <= i_awsize;
      w_burst <= i_awburst;
      w_bad   <= burst_bad(i_awlen, i_awsize, i_awburst);
      w_beat  <= '0;
      w_err   <= 1'b0;
    end else if (w_fire) begin
      w_addr <= w_nxt;
      w_beat <= w_beat + 8'd1;
      if (!w_ok || (i_wlast != w_last_beat)) w_err <= 1'b1;
    end
  end

  // Storage is deliberately not reset; w_fire is gated by state, so reset stops writes at once.
  always_ff @(posedge i_aclk) begin
    if (w_fire && w_ok) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (i_wstrb[b]) mem[w_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi4full_sram_burst.sv
// Directed bench for axi4full_sram_burst: bursts, narrow writes, SLVERR paths, concurrency and mid-burst reset.
// Inputs change and outputs are sampled on the falling edge of i_aclk.
module tb_axi4full_sram_burst;

  logic        i_aclk = 1'b0;
  logic        i_arsetn;
  logic [3:0]  i_awid, i_arid, o_bid, o_rid;
  logic [31:0] i_awaddr, i_araddr;
  logic [7:0]  i_awlen, i_arlen;
  logic [2:0]  i_awsize, i_arsize;
  logic [1:0]  i_awburst, i_arburst, o_bresp, o_rresp;
  logic        i_awvalid, o_awready, i_wlast, i_wvalid, o_wready, o_bvalid, i_bready;
  logic        i_arvalid, o_arready, o_rlast, o_rvalid, i_rready;
  logic [63:0] i_wdata, o_rdata;
  logic [7:0]  i_wstrb;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] wd_q[$];
  logic [7:0]  ws_q[$];

  localparam logic [63:0] WA = 64'hA0A1A2A3A4A5A6A7;
  localparam logic [63:0] WB = 64'hB0B1B2B3B4B5B6B7;
  localparam logic [63:0] WC = 64'hC0C1C2C3C4C5C6C7;
  localparam logic [63:0] WD = 64'hD0D1D2D3D4D5D6D7;

  axi4full_sram_burst dut (
    .i_aclk(i_aclk), .i_arsetn(i_arsetn),
    .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awsize(i_awsize),
    .i_awburst(i_awburst), .i_awvalid(i_awvalid), .o_awready(o_awready),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid),
    .o_wready(o_wready), .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid),
    .i_bready(i_bready), .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen),
    .i_arsize(i_arsize), .i_arburst(i_arburst), .i_arvalid(i_arvalid),
    .o_arready(o_arready), .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp),
    .o_rlast(o_rlast), .o_rvalid(o_rvalid), .i_rready(i_rready)
  );

  always #5 i_aclk = ~i_aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    i_awid = id; i_awaddr = addr; i_awlen = len; i_awsize = size; i_awburst = burst;
    i_awvalid = 1'b1;
    while (!o_awready && t < 50) begin @(negedge i_aclk); t++; end
    chk("aw_wait", 64'(t < 50), 64'd1);
    @(negedge i_aclk);
    i_awvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    i_arid = id; i_araddr = addr; i_arlen = len; i_arsize = size; i_arburst = burst;
    i_arvalid = 1'b1;
    while (!o_arready && t < 50) begin @(negedge i_aclk); t++; end
    chk("ar_wait", 64'(t < 50), 64'd1);
    @(negedge i_aclk);
    i_arvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [63:0] d, input logic [7:0] s, input logic last);
    int t = 0;
    i_wdata = d; i_wstrb = s; i_wlast = last; i_wvalid = 1'b1;
    while (!o_wready && t < 50) begin @(negedge i_aclk); t++; end
    chk("w_wait", 64'(t < 50), 64'd1);
    @(negedge i_aclk);
    i_wvalid = 1'b0;
  endtask

  // Full write burst from wd_q/ws_q, then the B handshake.
  task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst, input logic [1:0] resp);
    int t = 0;
    do_aw(id, addr, len, size, burst);
    for (int b = 0; b <= int'(len); b++) w_beat(wd_q[b], ws_q[b], b == int'(len));
    i_bready = 1'b1;
    while (!o_bvalid && t < 50) begin @(negedge i_aclk); t++; end
    chk("b_wait", 64'(t < 50), 64'd1);
    chk("bresp", 64'(o_bresp), 64'(resp));
    chk("bid", 64'(o_bid), 64'(id));
    @(negedge i_aclk);
    i_bready = 1'b0;
    chk("bvalid_clear", 64'(o_bvalid), 64'd0);
  endtask

  // Read burst checked against exp_q; toggle makes i_rready go 1,0,1,0...
  task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst, input logic [1:0] resp,
                    input bit toggle);
    int beat = 0;
    int cyc  = 0;
    do_ar(id, addr, len, size, burst);
    chk("r_latency", 64'(o_rvalid), 64'd1);
    while (beat <= int'(len) && cyc < 100) begin
      i_rready = toggle ? ~cyc[0] : 1'b1;
      chk("rvalid", 64'(o_rvalid), 64'd1);
      chk("rdata", o_rdata, exp_q[beat]);
      chk("rresp", 64'(o_rresp), 64'(resp));
      chk("rlast", 64'(o_rlast), 64'(beat == int'(len)));
      chk("rid", 64'(o_rid), 64'(id));
      chk("arready_busy", 64'(o_arready), 64'd0);
      if (i_rready) beat++;
      @(negedge i_aclk);
      cyc++;
    end
    i_rready = 1'b0;
    chk("r_budget", 64'(cyc < 100), 64'd1);
    chk("rvalid_done", 64'(o_rvalid), 64'd0);
    chk("arready_back", 64'(o_arready), 64'd1);
  endtask

  initial begin
    i_arsetn = 1'b0;
    i_awid = '0; i_awaddr = '0; i_awlen = '0; i_awsize = '0; i_awburst = '0; i_awvalid = 1'b0;
    i_wdata = '0; i_wstrb = '0; i_wlast = 1'b0; i_wvalid = 1'b0; i_bready = 1'b0;
    i_arid = '0; i_araddr = '0; i_arlen = '0; i_arsize = '0; i_arburst = '0; i_arvalid = 1'b0;
    i_rready = 1'b0;
    repeat (3) @(negedge i_aclk);
    chk("rst_rvalid", 64'(o_rvalid), 64'd0);
    chk("rst_bvalid", 64'(o_bvalid), 64'd0);
    chk("rst_wready", 64'(o_wready), 64'd0);
    chk("rst_rdata", o_rdata, 64'd0);
    chk("rst_rlast", 64'(o_rlast), 64'd0);
    chk("rst_rid_bid", 64'({o_rid, o_bid}), 64'd0);
    chk("rst_resp", 64'({o_rresp, o_bresp}), 64'd0);
    i_arsetn = 1'b1;
    @(negedge i_aclk);
    chk("rel_awready", 64'(o_awready), 64'd1);
    chk("rel_arready", 64'(o_arready), 64'd1);

    // Single beat write then read back
    wd_q = '{64'h1122334455667788}; ws_q = '{8'hFF};
    wr(4'd5, 32'h8000_0010, 8'd0, 3'd3, 2'b01, 2'b00);
    exp_q = '{64'h1122334455667788};
    rd(4'd3, 32'h8000_0010, 8'd0, 3'd3, 2'b01, 2'b00, 1'b0);

    // Preload words 0..3, then INCR read with stalls
    wd_q = '{WA, WB, WC, WD}; ws_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    wr(4'd1, 32'h8000_0000, 8'd3, 3'd3, 2'b01, 2'b00);
    exp_q = '{WA, WB, WC, WD};
    rd(4'd2, 32'h8000_0000, 8'd3, 3'd3, 2'b01, 2'b00, 1'b1);

    // WRAP from word 3 wraps to word 0; FIXED repeats word 1
    exp_q = '{WD, WA, WB, WC};
    rd(4'd4, 32'h8000_0018, 8'd3, 3'd3, 2'b10, 2'b00, 1'b0);
    exp_q = '{WB, WB, WB};
    rd(4'd6, 32'h8000_0008, 8'd2, 3'd3, 2'b00, 2'b00, 1'b0);

    // Narrow byte write into lane 3 of word 0
    wd_q = '{64'h0000_0000_AB00_0000}; ws_q = '{8'h08};
    wr(4'd7, 32'h8000_0003, 8'd0, 3'd0, 2'b01, 2'b00);
    exp_q = '{64'hA0A1A2A3ABA5A6A7};
    rd(4'd7, 32'h8000_0000, 8'd0, 3'd3, 2'b01, 2'b00, 1'b0);

    // Last word in range; then an out-of-range FIXED burst whose offset aliases onto that word
    wd_q = '{64'h0123456789ABCDEF}; ws_q = '{8'hFF};
    wr(4'd8, 32'h8000_1FF8, 8'd0, 3'd3, 2'b01, 2'b00);
    exp_q = '{64'd0, 64'd0};
    rd(4'd9, 32'h7FFF_FFF8, 8'd1, 3'd3, 2'b00, 2'b10, 1'b0);
    wd_q = '{64'hDEAD_BEEF_DEAD_BEEF, 64'hFEED_FACE_FEED_FACE}; ws_q = '{8'hFF, 8'hFF};
    wr(4'd10, 32'h7FFF_FFF8, 8'd1, 3'd3, 2'b00, 2'b10);
    exp_q = '{64'h0123456789ABCDEF};
    rd(4'd11, 32'h8000_1FF8, 8'd0, 3'd3, 2'b01, 2'b00, 1'b0);
    exp_q = '{64'd0};
    rd(4'd12, 32'h8000_2000, 8'd0, 3'd3, 2'b01, 2'b10, 1'b0);

    // Illegal WRAP length and oversized beat are whole-burst errors
    exp_q = '{64'd0, 64'd0, 64'd0};
    rd(4'd13, 32'h8000_0000, 8'd2, 3'd3, 2'b10, 2'b10, 1'b0);
    exp_q = '{64'd0};
    rd(4'd14, 32'h8000_0000, 8'd0, 3'd4, 2'b01, 2'b10, 1'b0);

    // Concurrent 4-beat read of words 0..3 and 4-beat write of words 8..11
    exp_q = '{64'hA0A1A2A3ABA5A6A7, WB, WC, WD};
    wd_q = '{64'hF0F0_0000_0000_0001, 64'hF1F1_0000_0000_0002,
             64'hF2F2_0000_0000_0003, 64'hF3F3_0000_0000_0004};
    ws_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    fork
      rd(4'd2, 32'h8000_0000, 8'd3, 3'd3, 2'b01, 2'b00, 1'b1);
      wr(4'd3, 32'h8000_0040, 8'd3, 3'd3, 2'b01, 2'b00);
    join
    exp_q = wd_q;
    rd(4'd1, 32'h8000_0040, 8'd3, 3'd3, 2'b01, 2'b00, 1'b0);

    // Reset in the middle of a write burst
    do_aw(4'd2, 32'h8000_0060, 8'd3, 3'd3, 2'b01);
    w_beat(64'hE0E0_E0E0_0000_0000, 8'hFF, 1'b0);
    w_beat(64'hE1E1_E1E1_0000_0000, 8'hFF, 1'b0);
    i_wdata = 64'hE2E2_E2E2_0000_0000; i_wvalid = 1'b1;
    chk("pre_rst_wready", 64'(o_wready), 64'd1);
    i_arsetn = 1'b0;
    #1;
    chk("rst_mid_wready", 64'(o_wready), 64'd0);
    chk("rst_mid_bvalid", 64'(o_bvalid), 64'd0);
    @(negedge i_aclk);
    i_wvalid = 1'b0;
    @(negedge i_aclk);
    i_arsetn = 1'b1;
    @(negedge i_aclk);
    chk("post_rst_awready", 64'(o_awready), 64'd1);
    chk("post_rst_arready", 64'(o_arready), 64'd1);
    exp_q = '{64'hE0E0_E0E0_0000_0000, 64'hE1E1_E1E1_0000_0000};
    rd(4'd5, 32'h8000_0060, 8'd1, 3'd3, 2'b01, 2'b00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4full_sram_burst.md
Name: axi4full_sram_burst

Overview:
- Next-generation AXI4-full slave memory, parametrised in data width, ID width, depth and base address.
- Holds an internal byte-maskable register-array SRAM.
- Supports multi-beat FIXED/INCR/WRAP bursts on independent read and write channels, narrow transfers, ID echo and SLVERR on out-of-range or illegal requests.
- Sits behind the core's AXI interconnect as simulation/FPGA main memory.

Parameters:
- DATA_WIDTH, 64, data bus width in bits (power of 2, ≥32)
- ADDR_WIDTH, 32, address width
- STRB_WIDTH, DATA_WIDTH/8, byte-strobe width
- ID_WIDTH, 4, AXI ID width
- DEPTH, 1024, number of DATA_WIDTH words
- BASE_ADDR, 32'h8000_0000, byte address of word 0

Ports:
- i_aclk  in  1  clock
- i_arsetn  in  1  reset; asynchronous, active-low
- i_awid/i_awaddr/i_awlen/i_awsize/i_awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address
- i_awvalid in 1; o_awready out 1
- i_wdata/i_wstrb/i_wlast  in  DATA_WIDTH/STRB_WIDTH/1  write data
- i_wvalid in 1; o_wready out 1
- o_bid/o_bresp  out  ID_WIDTH/2  write response
- o_bvalid out 1; i_bready in 1
- i_arid/i_araddr/i_arlen/i_arsize/i_arburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  read address
- i_arvalid in 1; o_arready out 1
- o_rid/o_rdata/o_rresp/o_rlast  out  ID_WIDTH/DATA_WIDTH/2/1  read data
- o_rvalid out 1; i_rready in 1

Behaviour:
- Reset (async assert, sync release):
  - FSMs go IDLE.
  - All valid/ready outputs 0, except o_awready/o_arready, which are 1 once reset is released.
  - o_rdata, o_rid, o_bid, o_rresp, o_bresp, o_rlast all 0.
  - Memory contents are not reset.
  - Reset mid-burst abandons the burst; no further writes occur.
- Read FSM, states R_IDLE and R_DATA:
  - o_arready = R_IDLE.
  - On ar_fire: latch id, addr, len, size, burst; clear beat counter; load o_rdata from mem[addr]; enter R_DATA. o_rvalid rises the next cycle, so latency is 1 cycle.
  - In R_DATA: o_rvalid = 1 and o_rlast = (beat == len).
  - On r_fire with !last: advance addr, increment beat, load the next word. No bubble; o_rvalid stays high.
  - On r_fire with last: return to R_IDLE, o_rvalid = 0. The next AR is accepted one cycle later.
  - o_rdata, o_rid, o_rresp and o_rlast are held stable while o_rvalid is high and i_rready is low.
- Write FSM, states W_IDLE, W_DATA and W_RESP:
  - o_awready = W_IDLE; o_wready = W_DATA.
  - On aw_fire: latch id, addr, len, size, burst; clear the error flag; enter W_DATA.
  - On each w_fire: write the bytes of mem[addr] whose i_wstrb bit is set; advance addr; increment beat.
  - On the w_fire where beat == len: enter W_RESP; o_bvalid = 1 next cycle.
  - If i_wlast ≠ (beat == len) on any beat, set the error flag.
  - On b_fire: return to W_IDLE.
- Channel independence:
  - Read and write channels are fully independent; both can be active in the same cycle.
  - Same-word read load and write in the same cycle: read returns the old data.
- Address generation (sz = 1<<size):
  - FIXED: addr unchanged.
  - INCR: next = (addr & ~(sz-1)) + sz.
  - WRAP: len must be 1, 3, 7 or 15. Lower bound lb = addr & ~((len+1)*sz-1). Next = incr result; if next == lb + (len+1)*sz, then next = lb.
  - All address arithmetic is ADDR_WIDTH wide and wraps modulo 2^ADDR_WIDTH.
  - Word index = (addr - BASE_ADDR) >> log2(STRB_WIDTH).
- Errors (resp 2'b10 SLVERR, otherwise 2'b00 OKAY):
  - A beat address outside [BASE_ADDR, BASE_ADDR + DEPTH*STRB_WIDTH) is an error for that beat.
  - size > log2(STRB_WIDTH), burst == 2'b11, or WRAP with an illegal len makes the whole burst an error.
  - Erroneous read beats return o_rdata = 0 with o_rresp = SLVERR. The burst still runs its full len+1 beats.
  - Erroneous write beats suppress the memory update and set the error flag. o_bresp = SLVERR if the flag is set.
- Handshakes:
  - Valid outputs never drop without the matching handshake.
  - Ready outputs depend only on state, never combinationally on valid.

Test Plan:
- Single beat: AW addr 0x8000_0010, len 0, size 3, wdata 0x1122334455667788, wstrb 0xFF, then AR same addr, len 0 -> o_bresp 0, o_bid = awid; o_rvalid 1 cycle after ar_fire, o_rdata 0x1122334455667788, o_rlast 1.
- INCR, len 3 read with i_rready toggling 1,0,1,0… from 0x8000_0000 (preloaded words 0..3 = A,B,C,D) -> beats A,B,C,D; data held during stalls; o_rlast only on the 4th beat; arready returns high 1 cycle after last r_fire.
- WRAP, len 3, size 3, AR 0x8000_0018 -> beats from words 3,0,1,2; FIXED len 2 at 0x8000_0008 -> word 1 returned three times.
- Narrow write: size 0, addr 0x8000_0003, wstrb 0x08, wdata byte3 = 0xAB -> only byte 3 of word 0 changes; other bytes keep prior values.
- Out of range: AR 0x7FFF_FFF8, len 1 -> two beats, rdata 0, rresp 2'b10; AW same address -> memory unchanged, bresp 2'b10.
- Concurrency/reset: simultaneous 4-beat read and 4-beat write to different words both complete correctly. Asserting i_arsetn low mid-write clears o_bvalid/o_wready immediately; after release awready = arready = 1 and the beats written before reset persist.
